memory_layer_gam: RTL and testbench

MEMORY_LAYER_GAM -- requirements
Module: memory_layer

---
 rtl/memory_layer_gam.sv | 164 ++++++++++++++++
 tb/tb_memory_layer_gam.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/memory_layer_gam.sv
// Growing associative memory: per-class node store, one-cycle SAD learn; optional recall under GAM_RECALL_EN.
// Latency: learn_* and recall outputs are registered, so they appear one cycle after the inputs; no backpressure, so new input is taken every cycle.
module memory_layer_gam #(
    parameter int CLASS_COUNT = 5,
    parameter int NODE_COUNT  = 6,
    parameter int LEARN_TH    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] x,
    input  logic [31:0]  c,
    input  logic         learning_done,
    input  logic         learning_recall,
`ifdef GAM_RECALL_EN
    input  logic [31:0]  Tk,
    output logic [127:0] recalling_pattern,
    output logic         recall_hit,
    output logic [31:0]  recall_class,
`endif
    output logic         learn_ins,
    output logic         learn_upd,
    output logic         learn_full
);
    localparam int CIW = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
    localparam int NIW = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
    localparam int CW  = $clog2(NODE_COUNT + 1);
    localparam logic [11:0]   TH    = 12'(LEARN_TH);
    localparam logic [CW-1:0] NFULL = CW'(NODE_COUNT);

    logic [127:0]          node [CLASS_COUNT][NODE_COUNT];
    logic [NODE_COUNT-1:0] vld  [CLASS_COUNT];
    logic [CW-1:0]         cnt  [CLASS_COUNT];

    function automatic logic [11:0] sad(input logic [127:0] a, input logic [127:0] b);
        logic [11:0] s;
        logic [7:0]  p;
        logic [7:0]  q;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            p = a[8*i +: 8];
            q = b[8*i +: 8];
            s = s + ((p > q) ? {4'd0, p - q} : {4'd0, q - p});
        end
        return s;
    endfunction

    logic           c_ok;
    logic           learn_cyc;
    logic [CIW-1:0] cls;
    logic [NIW-1:0] ins_idx;

    assign c_ok      = ($signed(c) >= 0) && ($signed(c) < CLASS_COUNT);
    assign cls       = c_ok ? c[CIW-1:0] : '0;
    assign learn_cyc = !learning_recall && !learning_done && c_ok;
    assign ins_idx   = NIW'(cnt[cls]);

    // Winner among valid nodes of class c; strict '<' keeps the lowest index on ties.
    logic           win_found;
    logic [NIW-1:0] win_idx;
    logic [11:0]    win_sad;
    logic [127:0]   win_pat;
    logic [11:0]    ld;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_sad   = '1;
        win_pat   = '0;
        ld        = '0;
        for (int n = 0; n < NODE_COUNT; n++) begin
            ld = sad(node[cls][n], x);
            if (vld[cls][n] && (!win_found || ld < win_sad)) begin
                win_found = 1'b1;
                win_idx   = NIW'(n);
                win_sad   = ld;
                win_pat   = node[cls][n];
            end
        end
    end

    logic [127:0] merged;
    logic [8:0]   lane_sum;

    always_comb begin
        merged   = '0;
        lane_sum = '0;
        for (int i = 0; i < 16; i++) begin
            lane_sum         = {1'b0, win_pat[8*i +: 8]} + {1'b0, x[8*i +: 8]};
            merged[8*i +: 8] = lane_sum[8:1];
        end
    end

`ifdef GAM_RECALL_EN
    // Global nearest node; class-major scan with strict '<' gives lowest class, then lowest node.
    logic           rc_found;
    logic [CIW-1:0] rc_cls;
    logic [11:0]    rc_sad;
    logic [127:0]   rc_pat;
    logic [11:0]    rd;
    logic           rc_hit;

    always_comb begin
        rc_found = 1'b0;
        rc_cls   = '0;
        rc_sad   = '1;
        rc_pat   = '0;
        rd       = '0;
        for (int k = 0; k < CLASS_COUNT; k++) begin
            for (int n = 0; n < NODE_COUNT; n++) begin
                rd = sad(node[k][n], x);
                if (vld[k][n] && (!rc_found || rd < rc_sad)) begin
                    rc_found = 1'b1;
                    rc_cls   = CIW'(k);
                    rc_sad   = rd;
                    rc_pat   = node[k][n];
                end
            end
        end
    end

    assign rc_hit = rc_found && !Tk[31] && ({20'd0, rc_sad} <= Tk);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CLASS_COUNT; k++) begin
                vld[k] <= '0;
                cnt[k] <= '0;
            end
            learn_ins  <= 1'b0;
            learn_upd  <= 1'b0;
            learn_full <= 1'b0;
`ifdef GAM_RECALL_EN
            recalling_pattern <= '0;
            recall_hit        <= 1'b0;
            recall_class      <= '0;
`endif
        end else begin
            learn_ins  <= 1'b0;
            learn_upd  <= 1'b0;
            learn_full <= 1'b0;
            if (learn_cyc) begin
                if (win_found && win_sad <= TH) begin
                    node[cls][win_idx] <= merged;
                    learn_upd          <= 1'b1;
                end else if (cnt[cls] < NFULL) begin
                    node[cls][ins_idx] <= x;
                    vld[cls][ins_idx]  <= 1'b1;
                    cnt[cls]           <= cnt[cls] + CW'(1);
                    learn_ins          <= 1'b1;
                end else begin
                    learn_full <= 1'b1;
                end
            end
`ifdef GAM_RECALL_EN
            if (learning_recall) begin
                recall_hit        <= rc_hit;
                recalling_pattern <= rc_hit ? rc_pat : x;
                recall_class      <= rc_hit ? {{(32-CIW){1'b0}}, rc_cls} : 32'd0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_memory_layer_gam.sv
// Scoreboard bench for memory_layer_gam: learn flags (and recall outputs with GAM_RECALL_EN) checked one cycle after drive.
module tb_memory_layer_gam;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] x;
    logic [31:0]  c;
    logic         learning_done;
    logic         learning_recall;
    logic         learn_ins, learn_upd, learn_full;
`ifdef GAM_RECALL_EN
    logic [31:0]  Tk;
    logic [127:0] recalling_pattern;
    logic         recall_hit;
    logic [31:0]  recall_class;
`endif

    memory_layer_gam dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .c                 (c),
        .learning_done     (learning_done),
        .learning_recall   (learning_recall),
`ifdef GAM_RECALL_EN
        .Tk                (Tk),
        .recalling_pattern (recalling_pattern),
        .recall_hit        (recall_hit),
        .recall_class      (recall_class),
`endif
        .learn_ins         (learn_ins),
        .learn_upd         (learn_upd),
        .learn_full        (learn_full)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NONE = 3'b000, INS = 3'b100, UPD = 3'b010, FULL = 3'b001;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] exp_q[$];
    string      tag_q[$];
`ifdef GAM_RECALL_EN
    logic [160:0] rexp_q[$];
`endif

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        logic [2:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 128'd1, 128'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {125'd0, learn_ins, learn_upd, learn_full}, {125'd0, e});
        end
`ifdef GAM_RECALL_EN
        if (rexp_q.size() != 0) begin
            logic [160:0] r;
            r = rexp_q.pop_front();
            chk({t, "_hit"}, {127'd0, recall_hit}, {127'd0, r[160]});
            chk({t, "_class"}, {96'd0, recall_class}, {96'd0, r[159:128]});
            chk({t, "_pattern"}, recalling_pattern, r[127:0]);
        end
`endif
    endtask

    task automatic drive(input logic [127:0] xv, input logic [31:0] cv, input logic [2:0] ef, input string tag);
        x = xv;
        c = cv;
        exp_q.push_back(ef);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

`ifdef GAM_RECALL_EN
    task automatic recall(input logic [127:0] xv, input logic [31:0] tk, input logic hit,
                          input logic [31:0] cls, input logic [127:0] pat, input string tag);
        learning_recall = 1'b1;
        Tk = tk;
        rexp_q.push_back({hit, cls, pat});
        drive(xv, 32'd1, NONE, tag);
        learning_recall = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; x = '0; c = '0; learning_done = 1'b0; learning_recall = 1'b0;
`ifdef GAM_RECALL_EN
        Tk = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {125'd0, learn_ins, learn_upd, learn_full}, 128'd0);
        chk("reset_cnt1", 128'(dut.cnt[1]), 128'd0);
        reset = 1'b0;

        // Same x/c held: one insert, then no-change updates.
        for (int i = 0; i < 10; i++)
            drive(128'd1234, 32'd1, (i == 0) ? INS : UPD, "hold_1234");
        chk("hold_cnt1", 128'(dut.cnt[1]), 128'd1);
        chk("hold_node", dut.node[1][0], 128'd1234);

        drive(128'd22313, 32'd1, INS, "far_insert");
        chk("far_cnt1", 128'(dut.cnt[1]), 128'd2);

`ifdef GAM_RECALL_EN
        recall(128'd1235, 32'd4, 1'b1, 32'd1, 128'd1234, "recall_tk4");
        recall(128'd1235, 32'd0, 1'b0, 32'd0, 128'd1235, "recall_tk0");
        recall(128'd1234, 32'hFFFF_FFFF, 1'b0, 32'd0, 128'd1234, "recall_tkneg");
        recall(128'd22313, 32'd0, 1'b1, 32'd1, 128'd22313, "recall_exact");
        drive(128'd5, 32'd9, NONE, "learn_hold_recall");
        chk("recall_hold_hit", {127'd0, recall_hit}, 128'd1);
        chk("recall_hold_pat", recalling_pattern, 128'd22313);
`endif

        drive(128'd1236, 32'd1, UPD, "near_update");
        chk("near_node", dut.node[1][0], 128'd1235);
        chk("near_other", dut.node[1][1], 128'd22313);

        for (int i = 0; i < 7; i++)
            drive({16{8'(i * 36)}}, 32'd2, (i < 6) ? INS : FULL, "class2_fill");
        chk("full_cnt2", 128'(dut.cnt[2]), 128'd6);
        chk("full_node0", dut.node[2][0], 128'd0);
        chk("full_node5", dut.node[2][5], {16{8'd180}});
        chk("full_class1", dut.node[1][0], 128'd1235);

        // Equidistant winners: lowest index takes the merge.
        drive(128'd0, 32'd3, INS, "tie_a");
        drive(128'd100, 32'd3, INS, "tie_b");
        drive(128'd50, 32'd3, UPD, "tie_upd");
        chk("tie_node0", dut.node[3][0], 128'd25);
        chk("tie_node1", dut.node[3][1], 128'd100);

        drive(128'd7, 32'd4, INS, "top_class");
        drive(128'd7, 32'd5, NONE, "class5_ignored");
        drive(128'd7, 32'hFFFF_FFFF, NONE, "class_neg_ignored");
        drive(128'd7, 32'd9, NONE, "class9_ignored");
        learning_done = 1'b1;
        drive(128'd99999, 32'd1, NONE, "done_ignored");
        learning_done = 1'b0;
        chk("ignored_cnt1", 128'(dut.cnt[1]), 128'd2);
        chk("ignored_cnt4", 128'(dut.cnt[4]), 128'd1);

        reset = 1'b1;
        drive(128'd4321, 32'd0, NONE, "reset_mid");
        reset = 1'b0;
        for (int k = 0; k < 5; k++)
            chk("reset_mid_cnt", 128'(dut.cnt[k]), 128'd0);
`ifdef GAM_RECALL_EN
        chk("reset_recall_hit", {127'd0, recall_hit}, 128'd0);
        chk("reset_recall_pat", recalling_pattern, 128'd0);
`endif
        drive(128'd1234, 32'd1, INS, "relearn_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
